div_unit: RTL and testbench

Iterative 32-bit radix-2 restoring divider serving the execute stage of the 5-stage MIPS CPU. The execute stage issues a DIV/DIVU request. This block accepts it, iterates for a fixed number of cycles, and returns quotient (LO) and remainder (HI). The execute stage then forwards these on its HI/LO write-data outputs with the double-write enable. While this block reports busy, the execute stage holds the pipeline.

---
 rtl/div_unit.sv | 145 ++++++++++++++
 tb/tb_div_unit.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// div_unit: iterative 32-bit radix-2 restoring divider (DIV/DIVU) for the
// execute stage. Each accepted request takes 32 CALC cycles, then one SIGN
// cycle, then one DONE cycle. Quotient goes to LO and remainder goes to HI.
module div_unit (
  input  logic        clk,
  input  logic        resetn,
  input  logic        div_req,
  input  logic        div_signed,
  input  logic [31:0] div_dividend,
  input  logic [31:0] div_divisor,
  input  logic        div_cancel,
  output logic        div_busy,
  output logic        div_done,
  output logic [31:0] div_lo,
  output logic [31:0] div_hi
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_SIGN = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  state_e      state_q, state_d;
  // The dividend shifts out MSB first while quotient bits shift in at the
  // LSB, so this register holds Q once the last iteration is done.
  logic [31:0] quo_q, quo_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] dvs_q, dvs_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] hi_q, hi_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        sgnq_q, sgnq_d;
  logic        sgnr_q, sgnr_d;

  logic [31:0] abs_a, abs_b;
  logic [32:0] trial;

  // Operand magnitudes. Negating 0x80000000 gives 0x80000000, which is then
  // read as an unsigned magnitude.
  always_comb begin
    abs_a = (div_signed & div_dividend[31]) ? (32'd0 - div_dividend) : div_dividend;
    abs_b = (div_signed & div_divisor[31])  ? (32'd0 - div_divisor)  : div_divisor;
  end

  // Trial subtraction: shifted partial remainder minus the divisor magnitude.
  // R stays below the divisor (or is at most 31 bits wide when the divisor
  // is 0), so bit 32 is the correct sign of the difference.
  always_comb begin
    trial = {rem_q, quo_q[31]} - {1'b0, dvs_q};
  end

  // Next-state, datapath and result logic.
  always_comb begin
    state_d = state_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dvs_d   = dvs_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    cnt_d   = cnt_q;
    sgnq_d  = sgnq_q;
    sgnr_d  = sgnr_q;
    unique case (state_q)
      ST_IDLE: begin
        if (div_req && !div_cancel) begin
          state_d = ST_CALC;
          sgnq_d  = div_signed & (div_dividend[31] ^ div_divisor[31]);
          sgnr_d  = div_signed & div_dividend[31];
          quo_d   = abs_a;
          dvs_d   = abs_b;
          rem_d   = 32'd0;
          cnt_d   = 5'd0;
        end
      end
      ST_CALC: begin
        if (div_cancel) begin
          state_d = ST_IDLE;
        end else begin
          if (!trial[32]) begin
            rem_d = trial[31:0];
            quo_d = {quo_q[30:0], 1'b1};
          end else begin
            rem_d = {rem_q[30:0], quo_q[31]};
            quo_d = {quo_q[30:0], 1'b0};
          end
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            state_d = ST_SIGN;
          end
        end
      end
      ST_SIGN: begin
        if (div_cancel) begin
          state_d = ST_IDLE;
        end else begin
          lo_d    = sgnq_q ? (32'd0 - quo_q) : quo_q;
          hi_d    = sgnr_q ? (32'd0 - rem_q) : rem_q;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers. Reset clears the whole divider at once.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      quo_q   <= 32'd0;
      rem_q   <= 32'd0;
      dvs_q   <= 32'd0;
      lo_q    <= 32'd0;
      hi_q    <= 32'd0;
      cnt_q   <= 5'd0;
      sgnq_q  <= 1'b0;
      sgnr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dvs_q   <= dvs_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      cnt_q   <= cnt_d;
      sgnq_q  <= sgnq_d;
      sgnr_q  <= sgnr_d;
    end
  end

  // All outputs are taken directly from registered state.
  always_comb begin
    div_busy = (state_q != ST_IDLE);
    div_done = (state_q == ST_DONE);
    div_lo   = lo_q;
    div_hi   = hi_q;
  end

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed self-checking bench for div_unit.
module tb_div_unit;

  logic        clk;
  logic        resetn;
  logic        div_req;
  logic        div_signed;
  logic [31:0] div_dividend;
  logic [31:0] div_divisor;
  logic        div_cancel;
  logic        div_busy;
  logic        div_done;
  logic [31:0] div_lo;
  logic [31:0] div_hi;

  int checks = 0;
  int errors = 0;

  div_unit dut (
    .clk          (clk),
    .resetn       (resetn),
    .div_req      (div_req),
    .div_signed   (div_signed),
    .div_dividend (div_dividend),
    .div_divisor  (div_divisor),
    .div_cancel   (div_cancel),
    .div_busy     (div_busy),
    .div_done     (div_done),
    .div_lo       (div_lo),
    .div_hi       (div_hi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Wait (bounded) until the divider is idle, then stop on a falling edge.
  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (div_busy && n < 100) begin
      @(negedge clk);
      n++;
    end
  endtask

  // Issue one request and wait for div_done. lat is the cycle offset of the
  // done cycle from the accept cycle (cycle k+1 is the first after accept),
  // or -1 on timeout. busy_cnt counts the cycles with div_busy high.
  task automatic do_op(input logic s, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] lo, output logic [31:0] hi,
                       output int lat, output int busy_cnt);
    wait_idle();
    div_signed   = s;
    div_dividend = a;
    div_divisor  = b;
    div_req      = 1'b1;
    @(posedge clk);
    #1;
    div_req  = 1'b0;
    lat      = -1;
    busy_cnt = 0;
    for (int cyc = 1; cyc <= 100; cyc++) begin
      if (div_busy) busy_cnt++;
      if (div_done) begin
        lat = cyc;
        break;
      end
      @(posedge clk);
      #1;
    end
    lo = div_lo;
    hi = div_hi;
    $display("op %s a=%08h b=%08h -> lo=%08h hi=%08h lat=%0d",
             s ? "DIV " : "DIVU", a, b, lo, hi, lat);
  endtask

  task automatic test_reset();
    resetn       = 1'b0;
    div_req      = 1'b0;
    div_signed   = 1'b0;
    div_dividend = 32'd0;
    div_divisor  = 32'd0;
    div_cancel   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (div_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", div_busy); end
    checks++; if (div_done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", div_done); end
    checks++; if (div_lo !== 32'd0) begin errors++; $display("FAIL reset_lo got=%08h exp=00000000", div_lo); end
    checks++; if (div_hi !== 32'd0) begin errors++; $display("FAIL reset_hi got=%08h exp=00000000", div_hi); end
    @(negedge clk);
    resetn = 1'b1;
    $display("reset released");
  endtask

  task automatic test_divu_basic();
    logic [31:0] lo, hi;
    int lat, bc;
    do_op(1'b0, 32'd100, 32'd7, lo, hi, lat, bc);
    checks++; if (lat !== 34) begin errors++; $display("FAIL divu_latency got=%0d exp=34", lat); end
    checks++; if (lo !== 32'd14) begin errors++; $display("FAIL divu_lo got=%08h exp=0000000e", lo); end
    checks++; if (hi !== 32'd2) begin errors++; $display("FAIL divu_hi got=%08h exp=00000002", hi); end
    checks++; if (bc !== 34) begin errors++; $display("FAIL divu_busy_cycles got=%0d exp=34", bc); end
    @(posedge clk);
    #1;
    checks++; if (div_busy !== 1'b0 || div_done !== 1'b0) begin
      errors++; $display("FAIL divu_after_done busy=%b done=%b exp=0/0", div_busy, div_done);
    end
  endtask

  task automatic test_signed();
    logic [31:0] lo, hi;
    int lat, bc;
    do_op(1'b1, 32'hFFFF_FFF9, 32'd2, lo, hi, lat, bc);
    checks++; if (lo !== 32'hFFFF_FFFD) begin errors++; $display("FAIL sdiv_m7_2_lo got=%08h exp=fffffffd", lo); end
    checks++; if (hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL sdiv_m7_2_hi got=%08h exp=ffffffff", hi); end
    checks++; if (lat !== 34) begin errors++; $display("FAIL sdiv_m7_2_latency got=%0d exp=34", lat); end
    do_op(1'b1, 32'd7, 32'hFFFF_FFFE, lo, hi, lat, bc);
    checks++; if (lo !== 32'hFFFF_FFFD) begin errors++; $display("FAIL sdiv_7_m2_lo got=%08h exp=fffffffd", lo); end
    checks++; if (hi !== 32'd1) begin errors++; $display("FAIL sdiv_7_m2_hi got=%08h exp=00000001", hi); end
  endtask

  task automatic test_overflow();
    logic [31:0] lo, hi;
    int lat, bc;
    do_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, lo, hi, lat, bc);
    checks++; if (lo !== 32'h8000_0000) begin errors++; $display("FAIL ovf_div_lo got=%08h exp=80000000", lo); end
    checks++; if (hi !== 32'd0) begin errors++; $display("FAIL ovf_div_hi got=%08h exp=00000000", hi); end
    do_op(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, lo, hi, lat, bc);
    checks++; if (lo !== 32'd0) begin errors++; $display("FAIL ovf_divu_lo got=%08h exp=00000000", lo); end
    checks++; if (hi !== 32'h8000_0000) begin errors++; $display("FAIL ovf_divu_hi got=%08h exp=80000000", hi); end
  endtask

  task automatic test_div_zero();
    logic [31:0] lo, hi;
    int lat, bc;
    do_op(1'b0, 32'd5, 32'd0, lo, hi, lat, bc);
    checks++; if (lo !== 32'hFFFF_FFFF) begin errors++; $display("FAIL divu_zero_lo got=%08h exp=ffffffff", lo); end
    checks++; if (hi !== 32'd5) begin errors++; $display("FAIL divu_zero_hi got=%08h exp=00000005", hi); end
    do_op(1'b1, 32'hFFFF_FFFB, 32'd0, lo, hi, lat, bc);
    checks++; if (lo !== 32'd1) begin errors++; $display("FAIL div_zero_lo got=%08h exp=00000001", lo); end
    checks++; if (hi !== 32'hFFFF_FFFB) begin errors++; $display("FAIL div_zero_hi got=%08h exp=fffffffb", hi); end
  endtask

  // Previous result is lo=1, hi=fffffffb; a cancelled op must leave it alone.
  task automatic test_cancel();
    logic [31:0] lo, hi;
    int lat, bc;
    wait_idle();
    div_signed   = 1'b0;
    div_dividend = 32'd100;
    div_divisor  = 32'd7;
    div_req      = 1'b1;
    @(posedge clk);
    #1;
    div_req = 1'b0;                  // now in cycle k+1
    repeat (9) begin
      @(posedge clk);
      #1;
    end                              // now in cycle k+10
    checks++; if (div_busy !== 1'b1) begin errors++; $display("FAIL cancel_busy_before got=%b exp=1", div_busy); end
    div_cancel = 1'b1;
    @(posedge clk);
    #1;
    div_cancel = 1'b0;               // now in cycle k+11
    $display("cancel issued at accept+10");
    checks++; if (div_busy !== 1'b0) begin errors++; $display("FAIL cancel_busy_after got=%b exp=0", div_busy); end
    checks++; if (div_done !== 1'b0) begin errors++; $display("FAIL cancel_done got=%b exp=0", div_done); end
    checks++; if (div_lo !== 32'd1) begin errors++; $display("FAIL cancel_lo_kept got=%08h exp=00000001", div_lo); end
    checks++; if (div_hi !== 32'hFFFF_FFFB) begin errors++; $display("FAIL cancel_hi_kept got=%08h exp=fffffffb", div_hi); end
    do_op(1'b0, 32'd100, 32'd7, lo, hi, lat, bc);
    checks++; if (lat !== 34) begin errors++; $display("FAIL cancel_next_latency got=%0d exp=34", lat); end
    checks++; if (lo !== 32'd14) begin errors++; $display("FAIL cancel_next_lo got=%08h exp=0000000e", lo); end
    checks++; if (hi !== 32'd2) begin errors++; $display("FAIL cancel_next_hi got=%08h exp=00000002", hi); end
  endtask

  task automatic test_cancel_with_req();
    wait_idle();
    div_signed   = 1'b0;
    div_dividend = 32'd50;
    div_divisor  = 32'd5;
    div_req      = 1'b1;
    div_cancel   = 1'b1;
    @(posedge clk);
    #1;
    div_req    = 1'b0;
    div_cancel = 1'b0;
    $display("req+cancel together in IDLE");
    checks++; if (div_busy !== 1'b0) begin errors++; $display("FAIL req_cancel_ignored busy=%b exp=0", div_busy); end
  endtask

  task automatic test_async_reset();
    logic [31:0] lo, hi;
    int lat, bc;
    wait_idle();
    div_signed   = 1'b0;
    div_dividend = 32'd100;
    div_divisor  = 32'd7;
    div_req      = 1'b1;
    @(posedge clk);
    #1;
    div_req = 1'b0;                  // cycle k+1
    repeat (19) begin
      @(posedge clk);
      #1;
    end                              // cycle k+20
    #2;
    resetn = 1'b0;
    #1;
    $display("async reset asserted at accept+20");
    checks++; if (div_busy !== 1'b0) begin errors++; $display("FAIL areset_busy got=%b exp=0", div_busy); end
    checks++; if (div_done !== 1'b0) begin errors++; $display("FAIL areset_done got=%b exp=0", div_done); end
    checks++; if (div_lo !== 32'd0) begin errors++; $display("FAIL areset_lo got=%08h exp=00000000", div_lo); end
    checks++; if (div_hi !== 32'd0) begin errors++; $display("FAIL areset_hi got=%08h exp=00000000", div_hi); end
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    do_op(1'b0, 32'd9, 32'd3, lo, hi, lat, bc);
    checks++; if (lat !== 34) begin errors++; $display("FAIL areset_next_latency got=%0d exp=34", lat); end
    checks++; if (lo !== 32'd3) begin errors++; $display("FAIL areset_next_lo got=%08h exp=00000003", lo); end
    checks++; if (hi !== 32'd0) begin errors++; $display("FAIL areset_next_hi got=%08h exp=00000000", hi); end
  endtask

  // div_req held high: operands change after the first accept and must only
  // be picked up by the second operation, which starts after one IDLE cycle.
  task automatic test_back_to_back();
    int lat;
    wait_idle();
    div_signed   = 1'b0;
    div_dividend = 32'd20;
    div_divisor  = 32'd6;
    div_req      = 1'b1;
    @(posedge clk);
    #1;
    div_dividend = 32'd21;
    div_divisor  = 32'd4;
    lat = -1;
    for (int cyc = 1; cyc <= 100; cyc++) begin
      if (div_done) begin lat = cyc; break; end
      @(posedge clk);
      #1;
    end
    $display("b2b op1 lo=%08h hi=%08h lat=%0d", div_lo, div_hi, lat);
    checks++; if (lat !== 34) begin errors++; $display("FAIL b2b_first_latency got=%0d exp=34", lat); end
    checks++; if (div_lo !== 32'd3 || div_hi !== 32'd2) begin
      errors++; $display("FAIL b2b_first_result lo=%08h hi=%08h exp=00000003/00000002", div_lo, div_hi);
    end
    @(posedge clk);
    #1;
    checks++; if (div_busy !== 1'b0) begin errors++; $display("FAIL b2b_idle_gap busy=%b exp=0", div_busy); end
    @(posedge clk);
    #1;
    div_req = 1'b0;
    checks++; if (div_busy !== 1'b1) begin errors++; $display("FAIL b2b_second_accept busy=%b exp=1", div_busy); end
    lat = -1;
    for (int cyc = 1; cyc <= 100; cyc++) begin
      if (div_done) begin lat = cyc; break; end
      @(posedge clk);
      #1;
    end
    $display("b2b op2 lo=%08h hi=%08h lat=%0d", div_lo, div_hi, lat);
    checks++; if (lat !== 34) begin errors++; $display("FAIL b2b_second_latency got=%0d exp=34", lat); end
    checks++; if (div_lo !== 32'd5 || div_hi !== 32'd1) begin
      errors++; $display("FAIL b2b_second_result lo=%08h hi=%08h exp=00000005/00000001", div_lo, div_hi);
    end
  endtask

  initial begin
    test_reset();
    test_divu_basic();
    test_signed();
    test_overflow();
    test_div_zero();
    test_cancel();
    test_cancel_with_req();
    test_async_reset();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "simulation did not finish");
  end

endmodule
